// File: rtl/inv_round_tf.sv
// Inverse AES round: InvMixColumns (if EN_IMC), InvShiftRows, InvSubBytes; one column/byte per cycle.
// Define INV_ROUND_TF_PAR_SBOX_EN for sixteen parallel inverse S-boxes (single-cycle InvSubBytes).
module inv_round_tf #(
   parameter int unsigned EN_IMC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] b_i,
   output logic [127:0] b_imc_o,
   output logic [127:0] b_isr_o,
   output logic [127:0] b_o,
   output logic         busy_o,
   output logic         done_o
);

   typedef enum logic [2:0] {StIdle, StImc, StIsr, StIsb, StDone} state_e;

   // Element 255 holds InvSbox(0x00), so a byte x is looked up at index ~x.
   localparam logic [255:0][7:0] InvSbox = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a constant whose set bits select a, 2a, 4a, 8a.
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] a2, a4, a8;
      a2 = xt(a);
      a4 = xt(a2);
      a8 = xt(a4);
      return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
              gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
              gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
              gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) begin
            r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c - w + 4) % 4) + w) -: 8];
         end
      end
      return r;
   endfunction

   state_e       state_q;
   logic [1:0]   col_q;
   logic [3:0]   idx_q;
   logic [127:0] st_q;

   logic [31:0]  col_in;
   logic [31:0]  col_out;
   logic [127:0] st_imc;
   logic [127:0] st_isr;
   logic [127:0] st_isb;

   always_comb begin
      col_in = '0;
      for (int c = 0; c < 4; c++) begin
         if (col_q == 2'(c)) col_in = st_q[127 - 32*c -: 32];
      end
      col_out = inv_mix_col(col_in);
      st_imc  = st_q;
      for (int c = 0; c < 4; c++) begin
         if (col_q == 2'(c)) st_imc[127 - 32*c -: 32] = col_out;
      end
      st_isr = inv_shift_rows(st_q);
   end

`ifdef INV_ROUND_TF_PAR_SBOX_EN
   localparam logic [3:0] IsbLast = 4'd0;

   always_comb begin
      st_isb = st_q;
      for (int k = 0; k < 16; k++) begin
         st_isb[127 - 8*k -: 8] = InvSbox[~st_q[127 - 8*k -: 8]];
      end
   end
`else
   localparam logic [3:0] IsbLast = 4'd15;

   logic [7:0] sb_in;
   logic [7:0] sb_out;

   always_comb begin
      sb_in = '0;
      for (int k = 0; k < 16; k++) begin
         if (idx_q == 4'(k)) sb_in = st_q[127 - 8*k -: 8];
      end
      sb_out = InvSbox[~sb_in];
      st_isb = st_q;
      for (int k = 0; k < 16; k++) begin
         if (idx_q == 4'(k)) st_isb[127 - 8*k -: 8] = sb_out;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         col_q   <= '0;
         idx_q   <= '0;
         st_q    <= '0;
         b_imc_o <= '0;
         b_isr_o <= '0;
         b_o     <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  st_q   <= b_i;
                  busy_o <= 1'b1;
                  col_q  <= '0;
                  idx_q  <= '0;
                  if (EN_IMC != 0) begin
                     state_q <= StImc;
                  end else begin
                     b_imc_o <= b_i;
                     state_q <= StIsr;
                  end
               end
            end
            StImc: begin
               st_q  <= st_imc;
               col_q <= col_q + 2'd1;
               if (col_q == 2'd3) begin
                  b_imc_o <= st_imc;
                  state_q <= StIsr;
               end
            end
            StIsr: begin
               st_q    <= st_isr;
               b_isr_o <= st_isr;
               idx_q   <= '0;
               state_q <= StIsb;
            end
            StIsb: begin
               st_q  <= st_isb;
               idx_q <= (idx_q == IsbLast) ? 4'd0 : idx_q + 4'd1;
               if (idx_q == IsbLast) begin
                  b_o     <= st_isb;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               done_o  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/inv_round_tf.md
Name: inv_round_tf

Overview:
- Inverse AES round transform: the decrypt-side counterpart of round_tf.
- Applies InvMixColumns (optional by parameter), then InvShiftRows, then InvSubBytes to a 128-bit state.
- Start/done handshake; intermediate results are exposed for debug.
- Area-lean datapath: InvMixColumns runs one column per cycle; InvSubBytes runs one byte per cycle through a single inverse S-box ROM.
- Sits in the decrypt path, after AddRoundKey, under the round controller.

Parameters:
- EN_IMC, 1: 1 = InvMixColumns stage executed; 0 = stage skipped (final-round form). b_imc_o then mirrors the latched input.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  start pulse; sampled only in IDLE
- b_i  in  128  input state; AES column-major, byte 0 = b_i[127:120], column c = bits [127-32c -: 32]
- b_imc_o  out  128  state after InvMixColumns
- b_isr_o  out  128  state after InvShiftRows
- b_o  out  128  final state after InvSubBytes
- busy_o  out  1  high from the cycle after start is accepted until done_o is asserted
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst high at a posedge):
  - FSM goes to IDLE; column and byte counters cleared.
  - All outputs go to 0: b_imc_o, b_isr_o, b_o, busy_o, done_o.
  - Applies mid-operation too; the in-flight result is discarded.
- FSM states: IDLE, IMC, ISR, ISB, DONE.
- IDLE:
  - start=1 at posedge E0: latch b_i into the working register; busy_o=1.
  - Next state is IMC if EN_IMC=1, else ISR.
  - start=0: stay in IDLE; outputs hold their last values.
- IMC (4 cycles, col 0..3):
  - Each edge replaces column col with InvMixColumns of that column, using GF(2^8) multiplies by 0e/0b/0d/09 and polynomial 0x11b.
  - After col=3: b_imc_o is loaded with the full result and the FSM goes to ISR.
- ISR (1 cycle):
  - Row r is rotated right by r byte positions.
  - b_isr_o is loaded; FSM goes to ISB with byte index 0.
- ISB (16 cycles, idx 0..15):
  - Byte idx is replaced by InvSbox(byte idx); one lookup per edge.
  - After idx=15: b_o is loaded, FSM goes to DONE, busy_o falls, done_o rises.
- DONE (1 cycle):
  - done_o=1.
  - Next edge: done_o falls and the FSM returns to IDLE.
- Latency from E0 to the first cycle with done_o high:
  - EN_IMC=1: 21 edges.
  - EN_IMC=0: 17 edges.
- start while busy or in DONE: ignored; it is not queued.
- Outputs hold after done until the next accepted start or reset. A new start does not clear them; each stage register is overwritten when that stage completes.
- EN_IMC=0: b_imc_o is loaded with the latched b_i at E0.
- Counters wrap only via the state transition; no out-of-range index is ever used.
- Functional requirement: inv_round_tf(round_tf(x)) = x for matching EN_IMC/EN_MC.

Optional Feature:
- Macro: INV_ROUND_TF_PAR_SBOX_EN.
- Defined:
  - Sixteen parallel inverse S-box instances; ISB completes in a single cycle.
  - Latency 6 edges (EN_IMC=1) or 2 edges (EN_IMC=0).
- Undefined: single shared S-box ROM with 16-cycle ISB, as described above.
- Results are identical either way; only latency differs.

Test Plan:
- EN_IMC=1, b_i=6379e6d9f467fb76ad063cf4d2eb8aa3, one-cycle start:
  - b_imc_o=63fcac161bee28c3c4c193f54b8233ea
  - b_isr_o=638293c31bfc33f5c4eeacea4bc12816
  - b_o=00112233445566778899aabbccddeeff
  - done_o pulses exactly 21 edges after start (6 edges with the macro); outputs unchanged 5 cycles later.
- EN_IMC=0, b_i=63fcac161bee28c3c4c193f54b8233ea:
  - b_imc_o equals b_i
  - b_o=00112233445566778899aabbccddeeff
  - done_o at 17 edges.
- Reset mid-operation: rst=1 during ISB byte 7:
  - Next cycle all outputs are 0 and FSM is IDLE.
  - A fresh start with the first vector yields the correct result.
- start held high for 3 cycles, plus a second start pulse mid-run:
  - Exactly one operation runs and one done_o pulse occurs.
  - busy_o stays high throughout.
- Back-to-back operations: second start in the cycle after DONE, with b_i=00000000000000000000000000000000 and EN_IMC=1:
  - b_o=52525252525252525252525252525252
  - The previous b_o holds until the ISB stage of the second operation completes.
- Round trip with round_tf: chain 100 random states through round_tf(EN_MC=1) and then inv_round_tf(EN_IMC=1) -> every output equals its original input.
